alu_sequencer: RTL and testbench

- Multicycle control FSM that sequences the processor's ALU through one instruction at a time.
- Accepts an opcode from the instruction source using a valid/ready handshake.
- Drives the shared State bus and flagALU into the ALU, and samples the ALU's flagBRANCH.
- Generates PC, register-file and memory strobes; waits on memory with a done handshake.

---
 rtl/alu_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multicycle ALU control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT)
// Optional retired/stall performance counters are enabled with ALU_SEQ_PERF_EN.
module alu_sequencer #(
    parameter int bitsOP  = 6,
    parameter int st      = 3,
    parameter int flag    = 2,
    parameter int HALT_OP = 63
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [bitsOP-1:0] OPCODE,
    input  logic              flagBRANCH,
    input  logic              mem_done,
    output logic [st-1:0]     State,
    output logic [flag-1:0]   flagALU,
    output logic              pcWrite,
    output logic [1:0]        pcSrc,
    output logic              regWrite,
    output logic              memRead,
    output logic              memWrite,
    output logic              illegal,
    output logic              halted
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]       retired_count,
    output logic [31:0]       stall_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [bitsOP-1:0] opcode_q, opcode_d;

    logic is_r, is_ld, is_st, is_jmp, is_sh, is_br, is_halt, is_ill;

    always_comb begin
        is_halt = (opcode_q == bitsOP'(HALT_OP));
        is_r    = (opcode_q == bitsOP'(0));
        is_ld   = (opcode_q == bitsOP'(1));
        is_st   = (opcode_q == bitsOP'(2));
        is_jmp  = (opcode_q == bitsOP'(3));
        is_sh   = (opcode_q == bitsOP'(4)) || (opcode_q == bitsOP'(5));
        is_br   = (opcode_q == bitsOP'(6)) || (opcode_q == bitsOP'(7));
        is_ill  = !(is_halt || is_r || is_ld || is_st || is_jmp || is_sh || is_br);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        instr_ready = 1'b0;
        flagALU     = '0;
        pcWrite     = 1'b0;
        pcSrc       = 2'd0;
        regWrite    = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    opcode_d = OPCODE;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt)     state_d = S_HALT;
                else if (is_jmp) state_d = S_WRITEBACK;
                else if (is_ill) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else         state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                // Load/store use the ALU only for the ADDI address calculation.
                if (is_r || is_ld || is_st)  flagALU = flag'(1);
                else if (is_sh || is_br)     flagALU = flag'(2);
                state_d = (is_ld || is_st) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                memRead  = is_ld;
                memWrite = is_st;
                if (mem_done) begin
                    // A store retires here since it has nothing to write back.
                    pcWrite = is_st;
                    state_d = is_ld ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                regWrite = is_r || is_sh || is_ld;
                pcWrite  = 1'b1;
                if (is_jmp)                  pcSrc = 2'd2;
                else if (is_br && flagBRANCH) pcSrc = 2'd1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign State = st'(state_q);

`ifdef ALU_SEQ_PERF_EN
    logic [31:0] retired_q, retired_d, stall_q, stall_d;

    always_comb begin
        retired_d = retired_q + {31'd0, pcWrite};
        stall_d   = stall_q + {31'd0, ((state_q == S_FETCH) && !instr_valid) ||
                                      ((state_q == S_MEMORY) && !mem_done)};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with an instruction-level reference model
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [5:0] OPCODE = 6'd0;
    logic       flagBRANCH = 1'b0;
    logic       mem_done = 1'b0;
    logic [2:0] State;
    logic [1:0] flagALU;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       illegal;
    logic       halted;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] retired_count;
    logic [31:0] stall_count;
`endif

    alu_sequencer dut (
        .clock(clock),
        .reset(reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .OPCODE(OPCODE),
        .flagBRANCH(flagBRANCH),
        .mem_done(mem_done),
        .State(State),
        .flagALU(flagALU),
        .pcWrite(pcWrite),
        .pcSrc(pcSrc),
        .regWrite(regWrite),
        .memRead(memRead),
        .memWrite(memWrite),
        .illegal(illegal),
        .halted(halted)
`ifdef ALU_SEQ_PERF_EN
        ,
        .retired_count(retired_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit [31:0] exp_ret = 0;
    bit [31:0] exp_stall = 0;

    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_JMP = 3, C_SH = 4, C_BR = 5, C_HALT = 6, C_ILL = 7;

    function automatic int cls_of(input int op);
        if (op == 63) return C_HALT;
        case (op)
            0:       return C_R;
            1:       return C_LD;
            2:       return C_ST;
            3:       return C_JMP;
            4, 5:    return C_SH;
            6, 7:    return C_BR;
            default: return C_ILL;
        endcase
    endfunction

    function automatic bit rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic int rop();
        return int'($urandom_range(0, 63));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs mid-cycle, advance past the edge.
    task automatic cyc(input bit v, input int op, input bit md, input bit fb,
                       input int es, input int ef, input int epw, input int eps,
                       input int erw, input int emr, input int emw, input int eil,
                       input int erdy, input int ehl);
        instr_valid = v;
        OPCODE      = 6'(op);
        mem_done    = md;
        flagBRANCH  = fb;
        @(negedge clock);
        chk("State",       32'(State),       es);
        chk("flagALU",     32'(flagALU),     ef);
        chk("pcWrite",     32'(pcWrite),     epw);
        chk("pcSrc",       32'(pcSrc),       eps);
        chk("regWrite",    32'(regWrite),    erw);
        chk("memRead",     32'(memRead),     emr);
        chk("memWrite",    32'(memWrite),    emw);
        chk("illegal",     32'(illegal),     eil);
        chk("instr_ready", 32'(instr_ready), erdy);
        chk("halted",      32'(halted),      ehl);
`ifdef ALU_SEQ_PERF_EN
        chk("retired_count", retired_count, exp_ret);
        chk("stall_count",   stall_count,   exp_stall);
`endif
        if (epw != 0) exp_ret++;
        if ((es == 0 && !v) || (es == 3 && !md)) exp_stall++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, rop(), rb(), rb(), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // Expected per-cycle behaviour of one instruction, built from its class.
    task automatic run_instr(input int op, input int waits, input bit br, input int idle);
        int c;
        c = cls_of(op);
        repeat (idle) idle_cyc();
        cyc(1'b1, op, rb(), rb(), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(rb(), rop(), rb(), rb(), 1, 0, 0, 0, 0, 0, 0, (c == C_ILL) ? 1 : 0, 0, 0);
        if (c == C_ILL || c == C_HALT) return;
        if (c != C_JMP)
            cyc(rb(), rop(), rb(), rb(), 2, (c == C_R || c == C_LD || c == C_ST) ? 1 : 2,
                0, 0, 0, 0, 0, 0, 0, 0);
        if (c == C_LD || c == C_ST) begin
            for (int w = 0; w <= waits; w++) begin
                bit md;
                md = (w == waits);
                cyc(rb(), rop(), md, rb(), 3, 0, (c == C_ST && md) ? 1 : 0, 0, 0,
                    (c == C_LD) ? 1 : 0, (c == C_ST) ? 1 : 0, 0, 0, 0);
            end
        end
        if (c != C_ST)
            cyc(rb(), rop(), rb(), br, 4, 0, 1,
                (c == C_JMP) ? 2 : ((c == C_BR && br) ? 1 : 0),
                (c == C_R || c == C_SH || c == C_LD) ? 1 : 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int op, sel;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        run_instr(0, 0, 1'b0, 0);
        run_instr(6, 0, 1'b1, 1);
        run_instr(6, 0, 1'b0, 0);
        run_instr(7, 0, 1'b1, 0);
        run_instr(1, 3, 1'b0, 0);
        run_instr(2, 0, 1'b0, 2);
        run_instr(2, 2, 1'b0, 0);
        run_instr(3, 0, 1'b1, 0);
        run_instr(4, 0, 1'b0, 0);
        run_instr(9, 0, 1'b0, 0);
        run_instr(62, 0, 1'b0, 1);

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            op  = (sel < 8) ? sel : int'($urandom_range(8, 62));
            run_instr(op, int'($urandom_range(0, 4)), rb(), int'($urandom_range(0, 2)));
        end

        // Reset while a load is stalled in MEMORY.
        cyc(1'b1, 1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 0, 1'b0, 1'b0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 0, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        cyc(1'b0, 0, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        reset = 1'b0;
        exp_ret = 0;
        exp_stall = 0;
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Halt is sticky even with a valid instruction offered.
        run_instr(63, 0, 1'b0, 1);
        repeat (10) cyc(1'b1, rop(), rb(), rb(), 5, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        cyc(1'b1, 0, 1'b0, 1'b0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        exp_ret = 0;
        exp_stall = 0;
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_instr(0, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
